// File: rtl/batchnorm_fp16_if.sv
// Stream, coefficient-load and output signals of the folded batch-norm stage.
// master = producer/loader side, slave = the batchnorm_fp16 block.
interface batchnorm_fp16_if #(
  parameter int CH_W = 6
);
  logic            cfg_we;
  logic [CH_W-1:0] cfg_addr;
  logic [15:0]     cfg_scale;
  logic [15:0]     cfg_shift;
  logic            bypass;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_data;
  logic            in_last;
  logic            bn_valid;
  logic [15:0]     bn_out;
  logic [CH_W-1:0] bn_ch;

  modport master (
    output cfg_we, cfg_addr, cfg_scale, cfg_shift, bypass, in_valid, in_data, in_last,
    input  in_ready, bn_valid, bn_out, bn_ch
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_scale, cfg_shift, bypass, in_valid, in_data, in_last,
    output in_ready, bn_valid, bn_out, bn_ch
  );
endinterface

// File: rtl/batchnorm_fp16.sv
// Folded batch-norm y = x*scale[ch] + shift[ch] on an FP16 stream, fixed 3-cycle latency.
// IEEE binary16 multiply/add, round-to-nearest-even, subnormals kept, NaN -> 16'h7E00.
module batchnorm_fp16 #(
  parameter int NUM_CH = 64,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input logic clk,
  input logic rst,
  batchnorm_fp16_if.slave bus
);
  localparam int STAGES = 3;

  function automatic logic [10:0] sig_of(input logic [15:0] h);
    return {|h[14:10], h[9:0]};
  endfunction

  function automatic int exp_of(input logic [15:0] h);
    return (h[14:10] == 5'd0) ? 1 : int'(h[14:10]);
  endfunction

  // Value represented is sig * 2^sc; normalise, round RNE and pack.
  function automatic logic [15:0] round_pack(input logic sgn, input logic [47:0] sig, input int sc);
    int          p, e, sh;
    logic [95:0] ext;
    logic [47:0] m;
    logic        g, st;
    round_pack = {sgn, 15'd0};
    if (sig != '0) begin
      p = 0;
      for (int i = 0; i < 48; i++) if (sig[i]) p = i;
      e = p + sc;
      if (e < -14) e = -14;
      sh = e - 10 - sc;
      if (sh <= 0) begin
        m  = sig << (-sh);
        g  = 1'b0;
        st = 1'b0;
      end else if (sh > 48) begin
        m  = '0;
        g  = 1'b0;
        st = 1'b1;
      end else begin
        ext = {sig, 48'd0} >> sh;
        m   = ext[95:48];
        g   = ext[47];
        st  = |ext[46:0];
      end
      if (g && (st || m[0])) m = m + 48'd1;
      if (m[11]) begin
        m = m >> 1;
        e = e + 1;
      end
      if (e > 15)      round_pack = {sgn, 5'h1f, 10'd0};
      else if (!m[10]) round_pack = {sgn, 5'd0, m[9:0]};
      else             round_pack = {sgn, 5'(e + 15), m[9:0]};
    end
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0] prod;
    sgn    = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    a_inf  = (a[14:0] == 15'h7c00);
    b_inf  = (b[14:0] == 15'h7c00);
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 16'h7E00;
    if (a_inf || b_inf) return {sgn, 5'h1f, 10'd0};
    prod = 22'(sig_of(a)) * 22'(sig_of(b));
    return round_pack(sgn, 48'(prod), exp_of(a) + exp_of(b) - 50);
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml;
    logic [47:0] sb, ss, sum;
    logic        sgn, a_nan, b_nan, a_inf, b_inf;
    int          d;
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    a_inf = (a[14:0] == 15'h7c00);
    b_inf = (b[14:0] == 15'h7c00);
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) return 16'h7E00;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[14:0] >= b[14:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    // Align by shifting the larger operand left: exact, rounding happens once.
    d  = exp_of(big) - exp_of(sml);
    sb = 48'(sig_of(big)) << d;
    ss = 48'(sig_of(sml));
    if (big[15] == sml[15]) begin
      sum = sb + ss;
      sgn = big[15];
    end else begin
      sum = sb - ss;
      sgn = (sum == '0) ? 1'b0 : big[15];
    end
    return round_pack(sgn, sum, exp_of(sml) - 25);
  endfunction

  typedef struct packed {
    logic [15:0]     x;
    logic [15:0]     scale;
    logic [15:0]     shift;
    logic [CH_W-1:0] ch;
    logic            bypass;
  } s1_t;

  typedef struct packed {
    logic [15:0]     x;
    logic [15:0]     p;
    logic [15:0]     shift;
    logic [CH_W-1:0] ch;
    logic            bypass;
  } s2_t;

  logic [NUM_CH-1:0][31:0] coef;  // {scale, shift}
  logic [STAGES-1:0]       vld_pipe;
  logic [CH_W-1:0]         ch_cnt;
  logic [15:0]             out_q;
  logic [CH_W-1:0]         ch_q;
  logic                    accept;
  s1_t                     s1;
  s2_t                     s2;

  assign bus.in_ready = !bus.cfg_we;
  assign accept       = bus.in_valid && !bus.cfg_we;
  assign bus.bn_valid = vld_pipe[STAGES-1];
  assign bus.bn_out   = out_q;
  assign bus.bn_ch    = ch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) coef[i] <= {16'h3C00, 16'h0000};
      vld_pipe <= '0;
      ch_cnt   <= '0;
      out_q    <= '0;
      ch_q     <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], accept};
      if (bus.cfg_we && (int'(bus.cfg_addr) < NUM_CH))
        coef[bus.cfg_addr] <= {bus.cfg_scale, bus.cfg_shift};
      if (accept) begin
        s1 <= '{x: bus.in_data, scale: coef[ch_cnt][31:16], shift: coef[ch_cnt][15:0],
                ch: ch_cnt, bypass: bus.bypass};
        if (bus.in_last || (ch_cnt == CH_W'(NUM_CH - 1))) ch_cnt <= '0;
        else                                              ch_cnt <= ch_cnt + 1'b1;
      end
      if (vld_pipe[0])
        s2 <= '{x: s1.x, p: fp_mul(s1.x, s1.scale), shift: s1.shift, ch: s1.ch, bypass: s1.bypass};
      if (vld_pipe[1]) begin
        out_q <= s2.bypass ? s2.x : fp_add(s2.p, s2.shift);
        ch_q  <= s2.ch;
      end
    end
  end
endmodule

// File: tb/tb_batchnorm_fp16.sv
// Bench for batchnorm_fp16: directed scenarios plus random traffic against a real-arithmetic FP16 model.
module tb_batchnorm_fp16;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  batchnorm_fp16_if #(.CH_W(CH_W)) bif ();
  batchnorm_fp16 #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

  typedef struct {
    int              cyc;
    logic [CH_W-1:0] ch;
    logic [15:0]     out;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  logic [15:0] m_scale[NUM_CH];
  logic [15:0] m_shift[NUM_CH];
  int          m_ch;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk)
    if (bif.bn_valid === 1'b1) obs_q.push_back('{cyc, bif.bn_ch, bif.bn_out});

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required the run to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: exact real arithmetic, rounded to FP16 ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real m;
    if (h[14:10] == 5'd0) m = real'(int'(h[9:0])) * pow2(-24);
    else                  m = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r, input logic zsign);
    logic s;
    real  a, m, f;
    int   e, mi;
    if (r == 0.0) return {zsign, 15'd0};
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= pow2(e + 1)) e++;
    while (a < pow2(e)) e--;
    if (e < -14) e = -14;
    m  = a / pow2(e - 10);
    mi = int'($floor(m));
    f  = m - real'(mi);
    if (f > 0.5 || (f == 0.5 && (mi % 2) == 1)) mi++;
    if (mi == 2048) begin
      mi = 1024;
      e++;
    end
    if (e > 15) return {s, 5'h1f, 10'd0};
    if (mi < 1024) return {s, 5'd0, mi[9:0]};
    return {s, 5'(e + 15), 10'(mi - 1024)};
  endfunction

  function automatic logic [15:0] bn_ref(input logic [15:0] x, input logic [15:0] sc,
                                         input logic [15:0] sh, input logic byp);
    logic [15:0] p;
    if (byp) return x;
    p = r2h(h2r(x) * h2r(sc), x[15] ^ sc[15]);
    return r2h(h2r(p) + h2r(sh), p[15] & sh[15]);
  endfunction

  function automatic logic [15:0] rnd_h(input int emin, input int emax);
    logic [15:0] h;
    h[15]    = 1'($urandom_range(0, 1));
    h[14:10] = 5'($urandom_range(emax, emin));
    h[9:0]   = 10'($urandom);
    return h;
  endfunction

  // Reset discards anything not yet delivered (due at or after the reset edge).
  task automatic model_reset();
    ev_t keep[$];
    for (int i = 0; i < NUM_CH; i++) begin
      m_scale[i] = 16'h3C00;
      m_shift[i] = 16'h0000;
    end
    m_ch = 0;
    foreach (exp_q[i]) if (exp_q[i].cyc < cyc) keep.push_back(exp_q[i]);
    exp_q = keep;
  endtask

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [15:0] x, input logic last, input logic byp,
                      input logic we, input logic [CH_W-1:0] addr, input logic [15:0] sc,
                      input logic [15:0] sh, input logic r);
    rst           = r;
    bif.in_valid  = v;
    bif.in_data   = x;
    bif.in_last   = last;
    bif.bypass    = byp;
    bif.cfg_we    = we;
    bif.cfg_addr  = addr;
    bif.cfg_scale = sc;
    bif.cfg_shift = sh;
    @(posedge clk);
    cyc++;
    if (r) model_reset();
    else if (we) begin
      m_scale[addr] = sc;
      m_shift[addr] = sh;
    end else if (v) begin
      exp_q.push_back('{cyc + 2, CH_W'(m_ch), bn_ref(x, m_scale[m_ch], m_shift[m_ch], byp)});
      m_ch = (last || m_ch == NUM_CH - 1) ? 0 : m_ch + 1;
    end
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic last, input logic byp);
    step(1'b1, x, last, byp, 1'b0, '0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 16'h0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 16'h0, 1'b1);
    checks++;
    if (bif.bn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", bif.bn_valid); end
    checks++;
    if (bif.bn_out !== 16'h0) begin errors++; $display("FAIL reset_out: got %h, required 0000", bif.bn_out); end
    checks++;
    if (bif.bn_ch !== '0) begin errors++; $display("FAIL reset_ch: got %0d, required 0", bif.bn_ch); end
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bif.in_ready); end
    idle(1);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_identity();
    int a;
    obs_q.delete();
    exp_q.delete();
    send(16'hC500, 1'b1, 1'b0);
    a = cyc;
    idle(4);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL identity_count: got %0d outputs, required 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].cyc != a + 2 || obs_q[0].out !== 16'hC500 || obs_q[0].ch !== '0) begin
        errors++;
        $display("FAIL identity: got cyc=%0d out=%h ch=%0d, required cyc=%0d out=c500 ch=0",
                 obs_q[0].cyc, obs_q[0].out, obs_q[0].ch, a + 2);
      end
    end
  endtask

  task automatic test_coeff_bypass();
    int          a;
    logic [15:0] req[4] = '{16'h4000, 16'h4000, 16'hBE00, 16'hC500};
    obs_q.delete();
    exp_q.delete();
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, '0, 16'h3800, 16'h3C00, 1'b0);
    send(16'h4000, 1'b1, 1'b0);
    a = cyc;
    send(16'h4000, 1'b1, 1'b1);
    send(16'hC500, 1'b1, 1'b0);
    send(16'hC500, 1'b1, 1'b1);
    idle(4);
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL coeff_count: got %0d outputs, required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i].cyc != a + 2 + i || obs_q[i].out !== req[i] || obs_q[i].ch !== '0) begin
          errors++;
          $display("FAIL coeff_bypass[%0d]: got cyc=%0d out=%h ch=%0d, required cyc=%0d out=%h ch=0",
                   i, obs_q[i].cyc, obs_q[i].out, obs_q[i].ch, a + 2 + i, req[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int a;
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    obs_q.delete();
    exp_q.delete();
    send(rnd_h(0, 22), 1'b0, 1'b0);
    a = cyc;
    repeat (5) send(rnd_h(0, 22), 1'b0, 1'b0);
    idle(4);
    checks++;
    if (obs_q.size() != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs, required 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_q[i].cyc != a + 2 + i || obs_q[i].ch !== CH_W'(seq[i]) || obs_q[i].out !== exp_q[i].out) begin
          errors++;
          $display("FAIL b2b[%0d]: got cyc=%0d ch=%0d out=%h, required cyc=%0d ch=%0d out=%h",
                   i, obs_q[i].cyc, obs_q[i].ch, obs_q[i].out, a + 2 + i, seq[i], exp_q[i].out);
        end
      end
    end
  endtask

  task automatic test_cfg_collision();
    obs_q.delete();
    exp_q.delete();
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(16'h3C00, 1'b0, 1'b0);
    bif.cfg_we = 1'b1;
    #1;
    checks++;
    if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL collide_ready: got %b, required 0", bif.in_ready); end
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, CH_W'(1), 16'h4000, 16'h3C00, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(16'h3C00, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      errors++;
      $display("FAIL collide_count: got %0d outputs, required 8", obs_q.size());
    end else begin
      checks++;
      if (obs_q[3].out !== 16'h3C00 || obs_q[7].out !== 16'h4200) begin
        errors++;
        $display("FAIL collide_coef: got old=%h new=%h, required old=3c00 new=4200", obs_q[3].out, obs_q[7].out);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].ch !== exp_q[i].ch || obs_q[i].out !== exp_q[i].out) begin
          errors++;
          $display("FAIL collide[%0d]: got cyc=%0d ch=%0d out=%h, required cyc=%0d ch=%0d out=%h", i,
                   obs_q[i].cyc, obs_q[i].ch, obs_q[i].out, exp_q[i].cyc, exp_q[i].ch, exp_q[i].out);
        end
      end
    end
  endtask

  task automatic test_in_last();
    int seq[6] = '{2, 0, 1, 2, 0, 1};
    obs_q.delete();
    exp_q.delete();
    send(rnd_h(0, 22), 1'b1, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(rnd_h(0, 22), 1'b1, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    idle(4);
    checks++;
    if (obs_q.size() != 6) begin
      errors++;
      $display("FAIL last_count: got %0d outputs, required 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_q[i].ch !== CH_W'(seq[i]) || obs_q[i].out !== exp_q[i].out || obs_q[i].cyc != exp_q[i].cyc) begin
          errors++;
          $display("FAIL last[%0d]: got ch=%0d out=%h cyc=%0d, required ch=%0d out=%h cyc=%0d", i,
                   obs_q[i].ch, obs_q[i].out, obs_q[i].cyc, seq[i], exp_q[i].out, exp_q[i].cyc);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int          a;
    logic [15:0] x;
    obs_q.delete();
    exp_q.delete();
    send(rnd_h(0, 22), 1'b0, 1'b0);
    send(rnd_h(0, 22), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bif.bn_valid !== 1'b0 || bif.bn_out !== 16'h0) begin
        errors++;
        $display("FAIL midreset[%0d]: got valid=%b out=%h, required valid=0 out=0000", i, bif.bn_valid, bif.bn_out);
      end
      if (i < 3) idle(1);
    end
    x = rnd_h(0, 22) | 16'h0001;
    send(x, 1'b0, 1'b0);
    a = cyc;
    idle(4);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d outputs, required 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].cyc != a + 2 || obs_q[0].ch !== '0 || obs_q[0].out !== x) begin
        errors++;
        $display("FAIL midreset_after: got cyc=%0d ch=%0d out=%h, required cyc=%0d ch=0 out=%h",
                 obs_q[0].cyc, obs_q[0].ch, obs_q[0].out, a + 2, x);
      end
    end
  endtask

  task automatic test_random();
    int r;
    obs_q.delete();
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8)
        step(1'($urandom_range(0, 1)), rnd_h(0, 22), 1'b0, 1'b0, 1'b1, CH_W'($urandom),
             rnd_h(8, 20), rnd_h(0, 24), 1'b0);
      else if (r < 9)
        step(1'b1, rnd_h(0, 22), 1'b0, 1'b0, 1'b0, '0, 16'h0, 16'h0, 1'b1);
      else
        step(($urandom_range(0, 3) != 0), rnd_h(0, 22), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 5) == 0), 1'b0, '0, 16'h0, 16'h0, 1'b0);
    end
    idle(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].ch !== exp_q[i].ch || obs_q[i].out !== exp_q[i].out) begin
        errors++;
        $display("FAIL rand[%0d]: got cyc=%0d ch=%0d out=%h, required cyc=%0d ch=%0d out=%h", i,
                 obs_q[i].cyc, obs_q[i].ch, obs_q[i].out, exp_q[i].cyc, exp_q[i].ch, exp_q[i].out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_coeff_bypass();
    test_back_to_back();
    test_cfg_collision();
    test_in_last();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
